uns_seq_mult: RTL and testbench
===============================

# uns_seq_mult

Parametrised sequential unsigned multiplier: a shift-and-add datapath driven by a small control FSM and an iteration counter. It generalises the fixed 3x3 repeated-addition multiplier to arbitrary operand widths and adds a BUSY/DONE handshake, so multi-cycle products can be requested by any controller in the design. With A_WIDTH = B_WIDTH = 3 it is a functional drop-in for the existing 3x3 unit, apart from latency and the handshake.

## Interface
- A_WIDTH, default 8: multiplicand width; legal range 2 or more.
- B_WIDTH, default 8: multiplier width; legal range 2 or more; sets the iteration count.
- SYS_CLOCK  in  1  system clock; all state updates on the rising edge.
- FSM_RESET  in  1  reset, synchronous, active-high.
- GO  in  1  start request; sampled only in IDLE.
- A  in  A_WIDTH  multiplicand; captured on the accepting edge.
- B  in  B_WIDTH  multiplier; captured on the accepting edge.
- F_REG  out  A_WIDTH+B_WIDTH  registered product; holds its value until the next completion.
- BUSY  out  1  high from the accepting edge until the FSM returns to IDLE.
- DONE  out  1  one-cycle pulse; F_REG is valid in the same cycle.

## Operation
- Internal registers:
  - A_REG: A_WIDTH+B_WIDTH bits, shifted left each iteration.
  - B_REG: B_WIDTH bits, shifted right each iteration.
  - ACC: A_WIDTH+B_WIDTH bits.
  - CNT: $clog2(B_WIDTH)+1 bits.
- States: IDLE, RUN, FIN.
- IDLE (BUSY=0, DONE=0):
  - GO=1 at an edge: A_REG<=zero-extended A, B_REG<=B, ACC<=0, CNT<=0, next state RUN.
  - GO=0: stay in IDLE.
- RUN (BUSY=1), on each edge:
  - acc_next = ACC + (B_REG[0] ? A_REG : 0).
  - ACC<=acc_next, A_REG<=A_REG<<1, B_REG<=B_REG>>1, CNT<=CNT+1.
  - If CNT==B_WIDTH-1: F_REG<=acc_next, next state FIN.
- FIN (BUSY=1, DONE=1): one cycle, then IDLE unconditionally.
- GO is ignored in RUN and FIN; a request is not queued.
- Changes on A or B after the accepting edge have no effect.
- Arithmetic is unsigned and never overflows: the full product fits in A_WIDTH+B_WIDTH bits. A and B both all-ones give (2^A_WIDTH-1)*(2^B_WIDTH-1).
- F_REG is written only on the completing edge. It is not cleared by GO.

## Timing
- Reset: state=IDLE; F_REG, ACC, A_REG, B_REG, CNT all 0; BUSY=0, DONE=0.
- Reset mid-operation: the operation aborts, F_REG reads 0, no DONE pulse. Reset takes priority over GO on the same edge.
- GO accepted at edge 0:
  - BUSY=1 after edge 0.
  - Iterations run on edges 1..B_WIDTH.
  - After edge B_WIDTH: DONE=1 and F_REG is valid.
  - After edge B_WIDTH+1: IDLE, BUSY=0.
- Earliest next acceptance is edge B_WIDTH+2. GO held high continuously gives one product every B_WIDTH+2 cycles.
- BUSY and DONE are registered state decodes with no combinational path from GO.

## Configuration
- Macro MULT_EARLY_DONE_EN.
- Defined: in RUN, if (B_REG>>1)==0 on an edge, F_REG<=acc_next and the next state is FIN regardless of CNT. Latency becomes (index of highest set bit of B)+1 iterations, minimum 1. B=0 and B=1 both finish after one RUN edge. Handshake rules are otherwise unchanged.
- Undefined: fixed latency of B_WIDTH iterations for every operand.

## Test plan
- A_WIDTH=B_WIDTH=3; reset, then GO with A=7, B=7 -> DONE after edge 3, F_REG=49; BUSY falls after edge 4.
- Default 8x8; A=255, B=255 -> F_REG=65025 with DONE after edge 8. A=0, B=200 -> F_REG=0 at the same edge.
- 8x8, macro defined: B=0 -> DONE after edge 1, F_REG=0. B=3, A=10 -> DONE after edge 2, F_REG=30. B=128, A=2 -> DONE after edge 8, F_REG=256. With the macro undefined, all three give DONE after edge 8.
- 8x8; GO with A=5, B=6, then GO pulsed on edges 3 and 9 with A=9, B=9 -> those pulses are ignored; F_REG=30; no second DONE.
- GO held high with A=3, B=4, then A=6, B=7 supplied after the first acceptance -> accepts at edges 0 and 10; F_REG=12, then 42; DONE pulses after edges 8 and 18.
- 8x8; A=100, B=100, FSM_RESET asserted at edge 4 -> F_REG=0, BUSY=0, no DONE. A fresh GO with A=100, B=100 at edge 6 -> F_REG=10000 with DONE after edge 14.

Source files
------------

// File: rtl/uns_seq_mult.sv
// rtl/uns_seq_mult.sv - shift-and-add unsigned multiplier with BUSY/DONE handshake
// Optional MULT_EARLY_DONE_EN: finish as soon as no multiplier bits remain.
module uns_seq_mult #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic                       SYS_CLOCK,
    input  logic                       FSM_RESET,
    input  logic                       GO,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    output logic [A_WIDTH+B_WIDTH-1:0] F_REG,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int CW = $clog2(B_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_a_reg;
    logic [PW-1:0]   r_acc;
    logic [B_WIDTH-1:0] r_b_reg;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_acc_next;
    logic            w_last;

    assign w_acc_next = r_acc + (r_b_reg[0] ? r_a_reg : '0);

`ifdef MULT_EARLY_DONE_EN
    // Stop once the bit being consumed is the last non-zero one.
    assign w_last = (r_cnt == CNT_LAST) || (r_b_reg[B_WIDTH-1:1] == '0);
`else
    assign w_last = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge SYS_CLOCK) begin
        if (FSM_RESET) begin
            r_state <= S_IDLE;
            r_a_reg <= '0;
            r_b_reg <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            F_REG   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (GO) begin
                        r_a_reg <= {{B_WIDTH{1'b0}}, A};
                        r_b_reg <= B;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        BUSY    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        BUSY    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a_reg <= r_a_reg << 1;
                    r_b_reg <= r_b_reg >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    BUSY    <= 1'b1;
                    if (w_last) begin
                        F_REG   <= w_acc_next;
                        DONE    <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uns_seq_mult.sv
// tb/tb_uns_seq_mult.sv - self-checking bench for uns_seq_mult (8x8 and 3x3)
// Honours MULT_EARLY_DONE_EN when computing expected latency.
module tb_uns_seq_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go8 = 1'b0;
    logic        go3 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [2:0]  a3 = '0;
    logic [2:0]  b3 = '0;
    logic [15:0] f8;
    logic [5:0]  f3;
    logic        busy8, done8, busy3, done3;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    uns_seq_mult #(.A_WIDTH(8), .B_WIDTH(8)) u_dut8 (
        .SYS_CLOCK(clk), .FSM_RESET(rst), .GO(go8), .A(a8), .B(b8),
        .F_REG(f8), .BUSY(busy8), .DONE(done8)
    );

    uns_seq_mult #(.A_WIDTH(3), .B_WIDTH(3)) u_dut3 (
        .SYS_CLOCK(clk), .FSM_RESET(rst), .GO(go3), .A(a3), .B(b3),
        .F_REG(f3), .BUSY(busy3), .DONE(done3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference latency: number of RUN iterations before DONE.
    function automatic int model_lat(input int b, input int bw);
`ifdef MULT_EARLY_DONE_EN
        int h;
        h = 0;
        for (int i = 0; i < bw; i++)
            if (((b >> i) & 1) == 1) h = i;
        return h + 1;
`else
        return bw;
`endif
    endfunction

    task automatic do_op(input bit sel3, input int a, input int b, input string tag);
        int bw;
        int lat;
        int n;
        bw  = sel3 ? 3 : 8;
        lat = model_lat(b, bw);
        @(negedge clk);
        if (sel3) begin a3 = a[2:0]; b3 = b[2:0]; go3 = 1'b1; end
        else      begin a8 = a[7:0]; b8 = b[7:0]; go8 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        go3 = 1'b0;
        go8 = 1'b0;
        chk({tag, " busy_after_accept"}, sel3 ? busy3 : busy8, 1);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (sel3 ? done3 : done8) break;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " product"}, sel3 ? f3 : f8, a * b);
        chk({tag, " busy_at_done"}, sel3 ? busy3 : busy8, 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " busy_fall"}, sel3 ? busy3 : busy8, 0);
        chk({tag, " done_pulse"}, sel3 ? done3 : done8, 0);
    endtask

    initial begin
        int l1, l2, lt;
        int ndone, dedge, d1, d2;
        logic [15:0] p1, p2;

        // Reset held with GO high: reset must win.
        go8 = 1'b1;
        go3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy8", busy8, 0);
        chk("rst done8", done8, 0);
        chk("rst f8", f8, 0);
        chk("rst busy3", busy3, 0);
        chk("rst f3", f3, 0);
        rst = 1'b0;
        go8 = 1'b0;
        go3 = 1'b0;

        do_op(1'b1, 7, 7, "m3_7x7");
        do_op(1'b0, 255, 255, "m8_max");
        do_op(1'b0, 0, 200, "m8_zeroA");
        do_op(1'b0, 77, 0, "m8_b0");
        do_op(1'b0, 10, 3, "m8_b3");
        do_op(1'b0, 2, 128, "m8_b128");
        do_op(1'b0, 200, 1, "m8_b1");

        // GO pulses during RUN and FIN are ignored.
        lt = model_lat(6, 8);
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd6; go8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
        ndone = 0;
        dedge = -1;
        for (int e = 1; e <= lt + 12; e++) begin
            go8 = (e == 3) || (e == lt + 1);
            @(posedge clk);
            @(negedge clk);
            if (done8) begin ndone++; dedge = e; end
        end
        go8 = 1'b0;
        chk("ign ndone", ndone, 1);
        chk("ign done_edge", dedge, lt);
        chk("ign product", f8, 30);
        chk("ign busy", busy8, 0);

        // GO held high: back-to-back products, operands changed after accept.
        l1 = model_lat(4, 8);
        l2 = model_lat(7, 8);
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4; go8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd6; b8 = 8'd7;
        d1 = -1; d2 = -1; p1 = '0; p2 = '0;
        for (int e = 1; e <= l1 + l2 + 4; e++) begin
            if (e == l1 + 3) go8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                if (d1 < 0) begin d1 = e; p1 = f8; end
                else begin d2 = e; p2 = f8; end
            end
        end
        go8 = 1'b0;
        chk("hold done1_edge", d1, l1);
        chk("hold product1", p1, 12);
        chk("hold done2_edge", d2, l1 + 2 + l2);
        chk("hold product2", p2, 42);
        chk("hold busy_end", busy8, 0);

        // Reset mid-operation aborts without DONE and clears F_REG.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; go8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b0;
        ndone = 0;
        for (int e = 1; e <= 4; e++) begin
            if (e == 4) rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort f8", f8, 0);
        chk("abort busy8", busy8, 0);
        chk("abort done8", done8, 0);
        chk("abort ndone", ndone, 0);
        rst = 1'b0;
        do_op(1'b0, 100, 100, "post_rst");

        for (int i = 0; i < 16; i++)
            do_op(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand8");
        for (int i = 0; i < 6; i++)
            do_op(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rand3");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
